uart_tx_fifo: RTL

Byte buffer and launch controller sitting directly upstream of `uart_tx`. Accepts bytes from a producer on a single-cycle write strobe, stores up to `DEPTH` of them, and feeds them one at a time to `uart_tx` through its `i_Tx_DV`/`i_Tx_Byte` inputs. It paces launches from `uart_tx`'s `o_Tx_Active`/`o_Tx_Done`. This lets firmware-side logic burst a message without tracking serializer timing.

---
 rtl/uart_pkg.sv | 20 ++
 rtl/uart_sync_fifo.sv | 59 +++++
 rtl/uart_tx_fifo.sv | 105 ++++++++++
 3 files changed

// File: rtl/uart_pkg.sv
`default_nettype none
// ============================================================================
// uart_pkg : constants and types shared by the UART TX buffer and its benches
// Revision : 1.0
// ============================================================================
package uart_pkg;

    localparam int BYTE_W       = 8;
    // 10 MHz / 115200 baud
    localparam int CLKS_PER_BIT = 87;

    typedef enum logic [1:0] {
        ST_IDLE      = 2'd0,
        ST_WAIT_BUSY = 2'd1,
        ST_WAIT_DONE = 2'd2,
        ST_GAP       = 2'd3
    } tx_state_e;

endpackage : uart_pkg
`default_nettype wire

// File: rtl/uart_sync_fifo.sv
`default_nettype none
// ============================================================================
// uart_sync_fifo : circular byte buffer with push/pop interface and flags
// Revision       : 1.0
// ============================================================================
module uart_sync_fifo
    import uart_pkg::*;
#(
    parameter  int DEPTH  = 16,
    localparam int ADDR_W = $clog2(DEPTH)
) (
    input  logic              i_Clock,
    input  logic              i_Rst_L,
    input  logic              i_Push,
    input  logic [BYTE_W-1:0] i_Push_Data,
    input  logic              i_Pop,
    output logic [BYTE_W-1:0] o_Pop_Data,
    output logic              o_Full,
    output logic              o_Empty,
    output logic [ADDR_W:0]   o_Count
);

    logic [BYTE_W-1:0] mem_q [DEPTH];
    logic [ADDR_W:0]   wr_ptr_q, wr_ptr_d;
    logic [ADDR_W:0]   rd_ptr_q, rd_ptr_d;
    logic              push_ok;
    logic              pop_ok;

    // Pointers carry one extra wrap bit so full and empty are distinguishable.
    always_comb begin
        o_Empty = (wr_ptr_q == rd_ptr_q);
        o_Full  = (wr_ptr_q[ADDR_W] != rd_ptr_q[ADDR_W]) &&
                  (wr_ptr_q[ADDR_W-1:0] == rd_ptr_q[ADDR_W-1:0]);
        o_Count = wr_ptr_q - rd_ptr_q;
        o_Pop_Data = mem_q[rd_ptr_q[ADDR_W-1:0]];
        push_ok = i_Push && !o_Full;
        pop_ok  = i_Pop && !o_Empty;
        wr_ptr_d = push_ok ? wr_ptr_q + 1'b1 : wr_ptr_q;
        rd_ptr_d = pop_ok  ? rd_ptr_q + 1'b1 : rd_ptr_q;
    end

    always_ff @(posedge i_Clock or negedge i_Rst_L) begin
        if (!i_Rst_L) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
        end
    end

    always_ff @(posedge i_Clock) begin
        if (push_ok) begin
            mem_q[wr_ptr_q[ADDR_W-1:0]] <= i_Push_Data;
        end
    end

endmodule : uart_sync_fifo
`default_nettype wire

// File: rtl/uart_tx_fifo.sv
`default_nettype none
// ============================================================================
// uart_tx_fifo : byte FIFO plus launch controller feeding uart_tx
// Revision     : 1.0
// ============================================================================
module uart_tx_fifo
    import uart_pkg::*;
#(
    parameter  int DEPTH  = 16,
    localparam int ADDR_W = $clog2(DEPTH)
) (
    input  logic              i_Clock,
    input  logic              i_Rst_L,
    input  logic              i_Wr_DV,
    input  logic [BYTE_W-1:0] i_Wr_Byte,
    input  logic              i_Clr_Ovf,
    input  logic              i_Tx_Active,
    input  logic              i_Tx_Done,
    output logic              o_Tx_DV,
    output logic [BYTE_W-1:0] o_Tx_Byte,
    output logic              o_Full,
    output logic              o_Empty,
    output logic [ADDR_W:0]   o_Count,
    output logic              o_Overflow
);

    tx_state_e         state_q, state_d;
    logic              tx_dv_q, tx_dv_d;
    logic [BYTE_W-1:0] tx_byte_q, tx_byte_d;
    logic              ovf_q, ovf_d;
    logic              pop;
    logic [BYTE_W-1:0] pop_data;

    uart_sync_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .i_Clock     (i_Clock),
        .i_Rst_L     (i_Rst_L),
        .i_Push      (i_Wr_DV),
        .i_Push_Data (i_Wr_Byte),
        .i_Pop       (pop),
        .o_Pop_Data  (pop_data),
        .o_Full      (o_Full),
        .o_Empty     (o_Empty),
        .o_Count     (o_Count)
    );

    // The Active gate in IDLE also covers a serializer still busy after our reset.
    always_comb begin
        state_d   = state_q;
        tx_dv_d   = 1'b0;
        tx_byte_d = tx_byte_q;
        pop       = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (!o_Empty && !i_Tx_Active) begin
                    tx_dv_d   = 1'b1;
                    tx_byte_d = pop_data;
                    pop       = 1'b1;
                    state_d   = ST_WAIT_BUSY;
                end
            end
            ST_WAIT_BUSY: begin
                if (i_Tx_Active) state_d = ST_WAIT_DONE;
            end
            ST_WAIT_DONE: begin
                if (i_Tx_Done) state_d = ST_GAP;
            end
            ST_GAP: begin
                if (!i_Tx_Done && !i_Tx_Active) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // A dropped write outranks a simultaneous clear.
    always_comb begin
        ovf_d = ovf_q;
        if (i_Wr_DV && o_Full) begin
            ovf_d = 1'b1;
        end else if (i_Clr_Ovf) begin
            ovf_d = 1'b0;
        end
    end

    always_ff @(posedge i_Clock or negedge i_Rst_L) begin
        if (!i_Rst_L) begin
            state_q   <= ST_IDLE;
            tx_dv_q   <= 1'b0;
            tx_byte_q <= '0;
            ovf_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            tx_dv_q   <= tx_dv_d;
            tx_byte_q <= tx_byte_d;
            ovf_q     <= ovf_d;
        end
    end

    assign o_Tx_DV    = tx_dv_q;
    assign o_Tx_Byte  = tx_byte_q;
    assign o_Overflow = ovf_q;

endmodule : uart_tx_fifo
`default_nettype wire
